// File: rtl/lcd_window_writer.sv
// lcd_window_writer: after init, writes CASET/PASET/RAMWR for one window,
// then streams pixel bytes MSB first through the shared byte transmitter.
module lcd_window_writer #(
    parameter int H_RES           = 320,
    parameter int V_RES           = 480,
    parameter int BYTES_PER_PIXEL = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_done,
    input  logic        start,
    input  logic [8:0]  x0,
    input  logic [8:0]  x1,
    input  logic [8:0]  y0,
    input  logic [8:0]  y1,
    input  logic        abort,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        tx_busy,
    output logic [7:0]  data_out,
    output logic        send_data,
    output logic        data_command,
    output logic        busy,
    output logic        frame_done,
    output logic        cfg_err
);
    typedef enum logic [3:0] {
        IDLE, CMD_CASET, PARAM_C, CMD_PASET, PARAM_P, CMD_RAMWR, PIX_FETCH, PIX_BYTE, DONE
    } state_t;

    localparam logic [9:0] LP_H    = 10'(H_RES);
    localparam logic [9:0] LP_V    = 10'(V_RES);
    localparam logic [1:0] LP_LAST = 2'(BYTES_PER_PIXEL - 1);

    state_t      r_state;
    logic        r_blank;
    logic [1:0]  r_idx;
    logic [8:0]  r_x0, r_x1, r_y0, r_y1;
    logic [17:0] r_cnt;
    logic [23:0] r_pix;
    logic        r_busy, r_frame_done, r_cfg_err;

    logic        w_bad, w_cmd, w_pend, w_send;
    logic [9:0]  w_w, w_h;
    logic [17:0] w_n;
    logic [8:0]  w_coord;
    logic [7:0]  w_param, w_pix, w_byte;
    logic [1:0]  w_sel;

    assign w_bad = (x0 > x1) || (y0 > y1) || ({1'b0, x1} >= LP_H) || ({1'b0, y1} >= LP_V);
    assign w_w   = {1'b0, x1} - {1'b0, x0} + 10'd1;
    assign w_h   = {1'b0, y1} - {1'b0, y0} + 10'd1;
    assign w_n   = {8'd0, w_w} * {8'd0, w_h};

    // The strobe looks at tx_busy in its own cycle; the blanking cycle after a
    // strobe covers the transmitter's latency in raising tx_busy.
    assign w_cmd  = (r_state == CMD_CASET) || (r_state == CMD_PASET) || (r_state == CMD_RAMWR);
    assign w_pend = w_cmd || (r_state == PARAM_C) || (r_state == PARAM_P) || (r_state == PIX_BYTE);
    assign w_send = w_pend && !r_blank && !tx_busy;

    assign w_coord = (r_state == PARAM_C) ? (r_idx[1] ? r_x1 : r_x0) : (r_idx[1] ? r_y1 : r_y0);
    assign w_param = r_idx[0] ? w_coord[7:0] : {7'd0, w_coord[8]};
    assign w_sel   = LP_LAST - r_idx;
    assign w_pix   = (w_sel == 2'd2) ? r_pix[23:16] : (w_sel == 2'd1) ? r_pix[15:8] : r_pix[7:0];
    assign w_byte  = (r_state == CMD_CASET) ? 8'h2A :
                     (r_state == CMD_PASET) ? 8'h2B :
                     (r_state == CMD_RAMWR) ? 8'h2C :
                     (r_state == PIX_BYTE)  ? w_pix : w_param;

    assign send_data    = w_send;
    assign data_out     = w_send ? w_byte : 8'h00;
    assign data_command = w_send && !w_cmd;
    assign pix_ready    = (r_state == PIX_FETCH);
    assign busy         = r_busy;
    assign frame_done   = r_frame_done;
    assign cfg_err      = r_cfg_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_blank      <= 1'b0;
            r_idx        <= 2'd0;
            r_x0         <= 9'd0;
            r_x1         <= 9'd0;
            r_y0         <= 9'd0;
            r_y1         <= 9'd0;
            r_cnt        <= 18'd0;
            r_pix        <= 24'd0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_blank      <= w_send;
            r_cfg_err    <= 1'b0;
            r_frame_done <= 1'b0;
            if (abort && r_state != IDLE) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: if (start && init_done) begin
                        if (w_bad) begin
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_x0    <= x0;
                            r_x1    <= x1;
                            r_y0    <= y0;
                            r_y1    <= y1;
                            r_cnt   <= w_n;
                            r_idx   <= 2'd0;
                            r_busy  <= 1'b1;
                            r_state <= CMD_CASET;
                        end
                    end
                    CMD_CASET: if (w_send) r_state <= PARAM_C;
                    PARAM_C: if (w_send) begin
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) r_state <= CMD_PASET;
                    end
                    CMD_PASET: if (w_send) r_state <= PARAM_P;
                    PARAM_P: if (w_send) begin
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) r_state <= CMD_RAMWR;
                    end
                    CMD_RAMWR: if (w_send) r_state <= PIX_FETCH;
                    PIX_FETCH: if (pix_valid) begin
                        r_pix   <= pix_data;
                        r_cnt   <= r_cnt - 18'd1;
                        r_idx   <= 2'd0;
                        r_state <= PIX_BYTE;
                    end
                    PIX_BYTE: if (w_send) begin
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == LP_LAST) begin
                            r_state      <= (r_cnt == 18'd0) ? DONE : PIX_FETCH;
                            r_frame_done <= (r_cnt == 18'd0);
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lcd_window_writer.sv
// tb_lcd_window_writer: random windows and pixels checked against a byte-list
// model of the ILI9488 window-write sequence, with a tx_busy/pixel-source BFM.
module tb_lcd_window_writer;
    logic        clk = 1'b0, rst_n = 1'b0, init_done = 1'b0, start = 1'b0, abort = 1'b0;
    logic        pix_valid = 1'b0, tx_busy = 1'b0;
    logic [8:0]  x0 = '0, x1 = '0, y0 = '0, y1 = '0;
    logic [23:0] pix_data = '0;
    logic        pix_ready, send_data, data_command, busy, frame_done, cfg_err;
    logic [7:0]  data_out;

    int checks = 0, errors = 0;

    lcd_window_writer dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done), .start(start),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .abort(abort),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .tx_busy(tx_busy), .data_out(data_out), .send_data(send_data),
        .data_command(data_command), .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // BFM state: owned by the bfm process, except the config written by tests
    logic [23:0] pix_mem [0:255];
    int          pix_n = 0, gen = 0;
    bit          tx_mode = 0, gap_mode = 0;
    logic [8:0]  cap [$];
    logic [8:0]  exp_q [$];
    int hs_cnt, frame_cnt, cfg_cnt, tx_viol, min_gap, max_gap, last_strobe, frame_cyc;
    int cyc = 0, seen_gen = 0, pidx = 0, bcnt = 0;
    bit st, hs;

    initial begin : bfm
        forever begin
            @(negedge clk);
            cyc++;
            if (gen != seen_gen) begin
                seen_gen = gen; pidx = 0; cap.delete(); hs_cnt = 0; frame_cnt = 0; cfg_cnt = 0;
                tx_viol = 0; min_gap = 1 << 30; max_gap = 0; last_strobe = -1; frame_cyc = -1;
            end
            st = send_data;
            hs = pix_valid && pix_ready;
            if (st) begin
                cap.push_back({data_command, data_out});
                if (tx_busy) tx_viol++;
                if (last_strobe >= 0) begin
                    if (cyc - last_strobe < min_gap) min_gap = cyc - last_strobe;
                    if (cyc - last_strobe > max_gap) max_gap = cyc - last_strobe;
                end
                last_strobe = cyc;
            end
            if (frame_done) begin frame_cnt++; frame_cyc = cyc; end
            if (cfg_err) cfg_cnt++;
            if (hs) begin hs_cnt++; pidx++; end
            @(posedge clk); #1;
            if (st) bcnt = 5;
            tx_busy = tx_mode && (bcnt > 0);
            if (bcnt > 0) bcnt--;
            pix_valid = (pidx < pix_n) && (!gap_mode || $urandom_range(0, 2) != 0);
            pix_data  = (pidx < pix_n && pidx < 256) ? pix_mem[pidx] : 24'h0;
        end
    end

    // Reference: the byte list a window write must produce, {d/c, byte}
    function automatic void build_exp(input logic [8:0] a0, a1, b0, b1);
        int n = (int'(a1) - int'(a0) + 1) * (int'(b1) - int'(b0) + 1);
        exp_q.delete();
        exp_q.push_back(9'h02A);
        exp_q.push_back({1'b1, 7'd0, a0[8]}); exp_q.push_back({1'b1, a0[7:0]});
        exp_q.push_back({1'b1, 7'd0, a1[8]}); exp_q.push_back({1'b1, a1[7:0]});
        exp_q.push_back(9'h02B);
        exp_q.push_back({1'b1, 7'd0, b0[8]}); exp_q.push_back({1'b1, b0[7:0]});
        exp_q.push_back({1'b1, 7'd0, b1[8]}); exp_q.push_back({1'b1, b1[7:0]});
        exp_q.push_back(9'h02C);
        for (int i = 0; i < n; i++)
            for (int b = 2; b >= 0; b--) exp_q.push_back({1'b1, pix_mem[i][8*b +: 8]});
    endfunction

    function automatic int diff_q(input logic [8:0] a [$], input logic [8:0] b [$]);
        for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] !== b[i]) return i;
        return (a.size() == b.size()) ? -1 : ((a.size() < b.size()) ? a.size() : b.size());
    endfunction

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) pix_mem[i] = 24'($urandom);
    endtask

    task automatic launch(input logic [8:0] a0, a1, b0, b1, input int n, input bit txm, gapm);
        pix_n = n; tx_mode = txm; gap_mode = gapm; gen++;
        @(posedge clk); #1;
        x0 = a0; x1 = a1; y0 = b0; y1 = b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        x0 = 9'($urandom); x1 = 9'($urandom); y0 = 9'($urandom); y1 = 9'($urandom);
    endtask

    task automatic wait_frame(input int budget);
        int c = 0;
        while (frame_cnt == 0 && c < budget) begin @(posedge clk); #1; c++; end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_bytes(input int k, input int budget);
        int c = 0;
        while (cap.size() < k && c < budget) begin @(posedge clk); #1; c++; end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, send_data, pix_ready, frame_done, cfg_err, data_command, data_out} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want all zero",
                     {busy, send_data, pix_ready, frame_done, cfg_err, data_command, data_out});
        end
        rst_n = 1'b1; init_done = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [8:0] lit [17] = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h101, 9'h02B, 9'h100, 9'h100, 9'h100,
                                 9'h100, 9'h02C, 9'h1FF, 9'h100, 9'h100, 9'h100, 9'h1FF, 9'h100};
        logic [8:0] lq [$];
        int d;
        pix_mem[0] = 24'hFF0000; pix_mem[1] = 24'h00FF00;
        launch(9'd0, 9'd1, 9'd0, 9'd0, 2, 0, 0);
        wait_frame(500);
        foreach (lit[i]) lq.push_back(lit[i]);
        d = diff_q(cap, lq);
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL basic_literal: byte %0d got %h want %h (%0d bytes, want 17)", d,
                     (d < cap.size()) ? cap[d] : 9'h0, lit[d % 17], cap.size());
        end
        build_exp(9'd0, 9'd1, 9'd0, 9'd0);
        d = diff_q(cap, exp_q);
        checks++;
        if (d != -1) begin errors++; $display("FAIL basic_model: first diff at byte %0d", d); end
        checks++;
        if (min_gap != 2 || max_gap != 2) begin
            errors++; $display("FAIL basic_spacing: gaps %0d..%0d want 2..2", min_gap, max_gap);
        end
        checks++;
        if (frame_cnt != 1 || frame_cyc != last_strobe + 1) begin
            errors++;
            $display("FAIL basic_frame_done: count %0d at cycle %0d, want 1 at %0d", frame_cnt, frame_cyc, last_strobe + 1);
        end
        checks++;
        if (hs_cnt != 2 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_handshake_busy: hs %0d busy %b, want 2 and 0", hs_cnt, busy);
        end
    endtask

    task automatic test_corner();
        logic [8:0] want [10] = '{9'h02A, 9'h101, 9'h12C, 9'h101, 9'h13F, 9'h02B, 9'h101, 9'h1D6, 9'h101, 9'h1DF};
        int d;
        fill(200);
        launch(9'd300, 9'd319, 9'd470, 9'd479, 200, 0, 0);
        wait_frame(5000);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (i >= cap.size() || cap[i] !== want[i]) begin
                errors++; $display("FAIL corner_setup[%0d]: got %h want %h", i, (i < cap.size()) ? cap[i] : 9'h0, want[i]);
            end
        end
        checks++;
        if (hs_cnt != 200 || cap.size() - 11 != 600) begin
            errors++; $display("FAIL corner_counts: hs %0d pixbytes %0d, want 200 and 600", hs_cnt, cap.size() - 11);
        end
        build_exp(9'd300, 9'd319, 9'd470, 9'd479);
        d = diff_q(cap, exp_q);
        checks++;
        if (d != -1 || frame_cnt != 1) begin
            errors++; $display("FAIL corner_model: diff at %0d frames %0d, want -1 and 1", d, frame_cnt);
        end
    endtask

    task automatic test_cfg_err();
        logic [8:0] cx0 [5] = '{9'd0, 9'd5, 9'd0, 9'd0, 9'd5};
        logic [8:0] cx1 [5] = '{9'd320, 9'd4, 9'd0, 9'd1, 9'd4};
        logic [8:0] cy1 [5] = '{9'd0, 9'd0, 9'd480, 9'd0, 9'd0};
        bit         cin [5] = '{1, 1, 1, 0, 0};
        int         ce  [5] = '{1, 1, 1, 0, 0};
        for (int k = 0; k < 5; k++) begin
            init_done = cin[k];
            launch(cx0[k], cx1[k], 9'd0, cy1[k], 0, 0, 0);
            repeat (6) @(posedge clk);
            #1;
            checks++;
            if (cfg_cnt != ce[k]) begin errors++; $display("FAIL cfg_err_%0d: pulses %0d want %0d", k, cfg_cnt, ce[k]); end
            checks++;
            if (cap.size() != 0 || busy !== 1'b0) begin
                errors++; $display("FAIL cfg_quiet_%0d: strobes %0d busy %b, want 0 and 0", k, cap.size(), busy);
            end
        end
        init_done = 1'b1;
    endtask

    task automatic test_flow();
        logic [8:0] a0, a1, b0, b1, ref_q [$];
        int d;
        for (int k = 0; k < 3; k++) begin
            a0 = 9'($urandom_range(0, 310)); a1 = a0 + 9'($urandom_range(0, 3));
            b0 = 9'($urandom_range(0, 470)); b1 = b0 + 9'($urandom_range(0, 2));
            fill(12);
            launch(a0, a1, b0, b1, 12, 0, 0);
            wait_frame(2000);
            ref_q = cap;
            launch(a0, a1, b0, b1, 12, 1, 1);
            wait_frame(5000);
            build_exp(a0, a1, b0, b1);
            d = diff_q(cap, exp_q);
            checks++;
            if (d != -1) begin errors++; $display("FAIL flow_model_%0d: first diff at byte %0d", k, d); end
            d = diff_q(cap, ref_q);
            checks++;
            if (d != -1) begin errors++; $display("FAIL flow_vs_fast_%0d: first diff at byte %0d", k, d); end
            checks++;
            if (tx_viol != 0 || min_gap < 2) begin
                errors++; $display("FAIL flow_txbusy_%0d: violations %0d min gap %0d, want 0 and >=2", k, tx_viol, min_gap);
            end
            checks++;
            if (frame_cnt != 1) begin errors++; $display("FAIL flow_frame_%0d: frames %0d want 1", k, frame_cnt); end
        end
        tx_mode = 0; gap_mode = 0;
    endtask

    task automatic test_abort();
        int thr [2] = '{2, 13};
        int sz, d;
        for (int k = 0; k < 2; k++) begin
            fill(8);
            launch(9'd10, 9'd13, 9'd20, 9'd21, 8, 0, 0);
            wait_bytes(thr[k], 500);
            checks++;
            if (cap.size() < thr[k]) begin errors++; $display("FAIL abort_reach_%0d: bytes %0d want >=%0d", k, cap.size(), thr[k]); end
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            checks++;
            if ({busy, pix_ready, send_data} !== 3'b000) begin
                errors++; $display("FAIL abort_next_%0d: busy/ready/send %b want 000", k, {busy, pix_ready, send_data});
            end
            sz = cap.size();
            repeat (10) @(posedge clk);
            #1;
            checks++;
            if (frame_cnt != 0 || busy !== 1'b0 || cap.size() != sz) begin
                errors++; $display("FAIL abort_quiet_%0d: frames %0d busy %b bytes %0d, want 0 0 %0d", k, frame_cnt, busy, cap.size(), sz);
            end
            fill(8);
            launch(9'd10, 9'd13, 9'd20, 9'd21, 8, 0, 0);
            wait_frame(1000);
            build_exp(9'd10, 9'd13, 9'd20, 9'd21);
            d = diff_q(cap, exp_q);
            checks++;
            if (d != -1 || frame_cnt != 1) begin
                errors++; $display("FAIL abort_restart_%0d: diff at %0d frames %0d, want -1 and 1", k, d, frame_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        int d;
        fill(16);
        launch(9'd0, 9'd3, 9'd0, 9'd3, 16, 0, 0);
        wait_bytes(14, 500);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, send_data, pix_ready, frame_done, cfg_err, data_command, data_out} !== 14'd0) begin
            errors++;
            $display("FAIL reset_async: got %b want all zero",
                     {busy, send_data, pix_ready, frame_done, cfg_err, data_command, data_out});
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, pix_ready, send_data, frame_done} !== 4'd0) begin
            errors++; $display("FAIL reset_idle: busy/ready/send/done %b want 0000", {busy, pix_ready, send_data, frame_done});
        end
        fill(1);
        launch(9'd7, 9'd7, 9'd9, 9'd9, 1, 0, 0);
        wait_frame(500);
        build_exp(9'd7, 9'd7, 9'd9, 9'd9);
        d = diff_q(cap, exp_q);
        checks++;
        if (cap.size() != 14 || d != -1) begin
            errors++; $display("FAIL single_pixel: %0d bytes diff at %0d, want 14 and -1", cap.size(), d);
        end
        checks++;
        if (frame_cnt != 1) begin errors++; $display("FAIL single_frame: frames %0d want 1", frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corner();
        test_cfg_err();
        test_flow();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/lcd_window_writer.md
Name: lcd_window_writer

Overview:
- Sequences one rectangular window write to the ILI9488 after LCD_init reports init_done.
- Issues Column Address Set (0x2A), Page Address Set (0x2B) and Memory Write (0x2C), then streams pixels from an upstream source.
- Drives the same byte-level transmitter interface as LCD_init: data_out, send_data, data_command.
- Sits between the pixel generator and the byte transmitter; owns the transmitter while busy is high.

Parameters:
- H_RES, 320, panel width in pixels; column limit for the range check.
- V_RES, 480, panel height in pixels; page limit for the range check.
- BYTES_PER_PIXEL, 3, bytes sent per pixel. Legal values are 2 (RGB565, pix_data[15:0]) and 3 (RGB666, pix_data[23:0]).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- init_done  in  1  high once LCD_init has completed.
- start  in  1  one-cycle request to begin a window write.
- x0  in  9  first column, sampled on accepted start.
- x1  in  9  last column, sampled on accepted start.
- y0  in  9  first page, sampled on accepted start.
- y1  in  9  last page, sampled on accepted start.
- abort  in  1  cancel the current window write.
- pix_data  in  24  pixel word, MSB byte sent first.
- pix_valid  in  1  pix_data is valid.
- pix_ready  out  1  block is accepting a pixel this cycle.
- tx_busy  in  1  byte transmitter is busy.
- data_out  out  8  byte to transmit.
- send_data  out  1  one-cycle transmit strobe.
- data_command  out  1  0 = command byte, 1 = parameter/pixel byte.
- busy  out  1  window write in progress.
- frame_done  out  1  one-cycle pulse after the last pixel byte.
- cfg_err  out  1  one-cycle pulse when start is rejected for range.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE, all outputs 0, all counters 0.
- start is accepted only in IDLE with init_done=1; otherwise it is ignored.
- Range check on accepted start: x0>x1, y0>y1, x1>=H_RES or y1>=V_RES gives a cfg_err pulse on the next cycle and the block stays in IDLE.
- On a valid start: latch coordinates; busy=1 from the next cycle.
- Byte strobe rule:
  - send_data is asserted for exactly one cycle, only when tx_busy=0 and a byte is pending.
  - data_out and data_command are stable in that cycle.
  - The cycle after a strobe is a blanking cycle; tx_busy is ignored there.
  - The next strobe requires tx_busy=0, so minimum strobe spacing is 2 cycles.
- Byte order:
  - 0x2A (cmd).
  - {7'b0,x0[8]}, x0[7:0], {7'b0,x1[8]}, x1[7:0] (data).
  - 0x2B (cmd).
  - y0 high/low, y1 high/low (data).
  - 0x2C (cmd).
  - Pixel bytes (data).
- States: IDLE -> CMD_CASET -> PARAM (4 bytes) -> CMD_PASET -> PARAM (4 bytes) -> CMD_RAMWR -> PIX_FETCH -> PIX_BYTE -> ... -> DONE -> IDLE.
- Pixel count N = (x1-x0+1)*(y1-y0+1), held in an 18-bit down-counter; maximum 153600.
- PIX_FETCH:
  - pix_ready=1 until pix_valid=1.
  - Handshake is pix_valid & pix_ready; pix_data is latched that cycle.
  - pix_ready is 0 in every other state.
- PIX_BYTE: sends BYTES_PER_PIXEL bytes MSB first, then returns to PIX_FETCH, or goes to DONE when the count reaches 0.
- pix_valid low stalls the block indefinitely with no strobes; the last byte may be left pending.
- DONE: frame_done=1 for one cycle, busy=0 on the next cycle, return to IDLE. start is accepted again in IDLE.
- abort:
  - Sampled every cycle; any non-IDLE state goes to IDLE next cycle.
  - send_data, pix_ready and busy go low next cycle; no frame_done.
  - A strobe issued in the same cycle as abort still completes.
- start while busy is ignored; coordinate inputs may change freely after acceptance.
- Single-pixel window (x0=x1, y0=y1): N=1, fully legal.
- init_done falling mid-write has no effect; only abort or reset cancels.

Test Plan:
- Window x 0..1, y 0..0, BPP 3, tx_busy held 0, pix_data 0xFF0000 then 0x00FF00:
  - Expect bytes 2A, 00, 00, 00, 01, 2B, 00, 00, 00, 00, 2C, FF, 00, 00, 00, FF, 00.
  - D/C pattern: 0 1111 0 1111 0 111111.
  - Strobes 2 cycles apart; frame_done once after the last byte.
- Window x 300..319, y 470..479:
  - Expect x0 bytes 01/2C, x1 01/3F, y0 01/D6, y1 01/DF.
  - Exactly 200 pix_ready handshakes and 600 pixel strobes.
- start with x1=320 or x0=5,x1=4:
  - Expect cfg_err pulse and no send_data.
  - start while init_done=0: no cfg_err, no strobes.
- tx_busy model (high 5 cycles after each strobe) plus random pix_valid gaps:
  - Byte stream identical to the tx_busy=0 run.
  - No strobe while tx_busy=1 outside the blanking cycle.
- abort during PARAM and during PIX_BYTE:
  - busy/pix_ready/send_data low next cycle; no frame_done.
  - A new start then produces a full correct sequence beginning with 0x2A.
- rst_n pulsed low mid-frame:
  - All outputs 0 asynchronously; block in IDLE after release.
  - Single-pixel window afterwards: 11 setup bytes plus 3 pixel bytes, then frame_done.
